sort_sequencer: RTL and testbench
=================================

Name: sort_sequencer

Overview:
- Buffers a frame of up to DEPTH signed N-bit words, sorts them ascending with in-place bubble sort, then streams them out.
- One shared comparator_lt instance performs every comparison. The sort is one comparison per clock.
- Sits between a valid/ready producer and consumer. It is the first sequential user of the signed less-than datapath.

Parameters:
- N, 32, data width; two's-complement signed.
- DEPTH, 8, maximum frame length; must be >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_data  input  N  signed word.
- in_last  input  1  marks final word of the frame; qualified by in_valid & in_ready.
- in_ready  output  1  block accepts a word this cycle.
- out_valid  output  1  out_data holds a sorted word.
- out_data  output  N  sorted word, smallest first.
- out_last  output  1  current output word is the frame's last.
- out_ready  input  1  consumer accepts the word this cycle.
- busy  output  1  high in S_SORT.

Behaviour:
- Storage: mem[0..DEPTH-1] of N bits; count holds the number of loaded words, range 0..DEPTH.
- Reset (rst high at an edge, from any state, including mid-sort or mid-drain): state=S_LOAD, count=0, pass/index/swapped cleared.
  - in_ready, out_valid, out_last, busy are all 0 while rst is high.
  - mem contents are don't-care.
- S_LOAD:
  - in_ready=1, out_valid=0, busy=0.
  - On in_valid & in_ready: mem[count]<=in_data, count<=count+1.
  - Go to S_SORT on the edge that accepts a word with in_last=1, or that accepts the DEPTH-th word (in_last ignored then).
  - A frame of exactly 1 word still passes through S_SORT, which exits after 1 cycle.
  - No words accepted: remain in S_LOAD indefinitely.
- S_SORT:
  - in_ready=0, out_valid=0, busy=1.
  - Index i runs 0..count-2. Each cycle, the comparator evaluates lt = (mem[i+1] < mem[i]) as signed.
  - If lt: swap mem[i] and mem[i+1] at the edge and set swapped=1.
  - Equal values never swap, so the sort is stable.
  - At i=count-2, the end of a pass:
    - if swapped (including this cycle's swap), clear swapped, i<=0, start a new pass;
    - else go to S_DRAIN with rd_idx=0.
  - count==1: go to S_DRAIN after 1 cycle with no comparison.
  - Latency bound: at most count passes of (count-1) cycles. Already-sorted input takes exactly count-1 cycles.
- S_DRAIN:
  - out_valid=1, out_data=mem[rd_idx], out_last=(rd_idx==count-1), in_ready=0, busy=0.
  - On out_ready: rd_idx<=rd_idx+1.
  - If out_last & out_ready: count<=0, go to S_LOAD.
  - out_data is stable while out_valid & !out_ready.
- Comparator use:
  - Exactly one comparator_lt #(.N(N)) instance in the block.
  - Its operand muxes are driven by i. Its output is used only in S_SORT.
- Widths:
  - count is $clog2(DEPTH+1) bits.
  - i and rd_idx are $clog2(DEPTH) bits.
  - No arithmetic is performed on data; only compare and move.
- Throughput: no overlap between frames. A new load begins the cycle after the final handshake of the drain.

Test Plan:
- Reset mid-sort:
  - Stimulus: load 8,7,6,5,4,3,2,1 (DEPTH=8); assert rst for 1 cycle at the 5th S_SORT cycle.
  - Response: next cycle in_ready=1, busy=0, out_valid=0.
  - Then load 3,1,2 with in_last on 2 and drain: outputs 1,2,3, out_last on 3.
- Signed ordering:
  - Stimulus: frame 5, -1, 0x80000000, 0x7FFFFFFF, 0, -7, 2, -1.
  - Response: output 0x80000000, -7, -1, -1, 0, 2, 5, 0x7FFFFFFF; out_last only on the 8th word.
- Sorted input latency:
  - Stimulus: load 1..8 ascending.
  - Response: busy high exactly 7 cycles; output 1..8.
  - Reverse input 8..1: busy high <= 64 cycles; output 1..8.
- Short frames:
  - Stimulus: single word 42 with in_last.
  - Response: busy high 1 cycle; one output 42 with out_last=1.
  - Stimulus: 2-word frame 9, -9.
  - Response: -9, 9.
- Backpressure:
  - Stimulus: during drain, toggle out_ready 1,0,0,1,…
  - Response: out_data holds while stalled; no words dropped or duplicated; in_ready stays 0 until after the out_last handshake.
- Input stalls:
  - Stimulus: in_valid gaps between words in S_LOAD.
  - Response: only handshaked words are stored; count matches accepted words.
  - Response: a ninth word offered after the 8th is not accepted (in_ready=0).

Source files
------------

// File: rtl/sort_sequencer.sv
// Frame buffer that bubble-sorts up to DEPTH signed words in place, one compare per clock,
// between a valid/ready producer and consumer. Includes the shared signed comparator.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

// state   | meaning
// S_LOAD  | accepting words into mem until in_last or DEPTH words
// S_SORT  | bubble sort, one adjacent compare/swap per clock
// S_DRAIN | streaming mem out in ascending order
module sort_sequencer #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic           swapped_q, swapped_d;
    logic [N-1:0]   mem_q [DEPTH];
    logic [N-1:0]   mem_d [DEPTH];

    logic [N-1:0]   cmp_a;
    logic [N-1:0]   cmp_b;
    logic           cmp_lt;
    logic           pass_end;
    logic           drain_last;

    // Operands are always the adjacent pair selected by idx; lt is only consumed in S_SORT.
    assign cmp_a = mem_q[idx_q + IW'(1)];
    assign cmp_b = mem_q[idx_q];

    comparator_lt #(.N(N)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (cmp_lt)
    );

    assign pass_end   = (CW'(idx_q) == (count_q - CW'(2)));
    assign drain_last = (CW'(rd_idx_q) == (count_q - CW'(1)));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        idx_d     = idx_q;
        rd_idx_d  = rd_idx_q;
        swapped_d = swapped_q;
        mem_d     = mem_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = mem_q[rd_idx_q];

        case (state_q)
            S_LOAD: begin
                in_ready = !rst;
                if (in_valid) begin
                    mem_d[count_q[IW-1:0]] = in_data;
                    count_d = count_q + CW'(1);
                    if (in_last || (count_q == CW'(DEPTH - 1))) begin
                        state_d   = S_SORT;
                        idx_d     = '0;
                        swapped_d = 1'b0;
                    end
                end
            end
            S_SORT: begin
                busy = !rst;
                if (count_q == CW'(1)) begin
                    state_d  = S_DRAIN;
                    rd_idx_d = '0;
                end else begin
                    if (cmp_lt) begin
                        mem_d[idx_q]          = cmp_a;
                        mem_d[idx_q + IW'(1)] = cmp_b;
                    end
                    if (pass_end) begin
                        if (swapped_q || cmp_lt) begin
                            idx_d     = '0;
                            swapped_d = 1'b0;
                        end else begin
                            state_d  = S_DRAIN;
                            rd_idx_d = '0;
                        end
                    end else begin
                        idx_d     = idx_q + IW'(1);
                        swapped_d = swapped_q | cmp_lt;
                    end
                end
            end
            S_DRAIN: begin
                out_valid = !rst;
                out_last  = !rst && drain_last;
                if (out_ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (drain_last) begin
                        count_d = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_LOAD;
            count_q   <= '0;
            idx_q     <= '0;
            rd_idx_q  <= '0;
            swapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            rd_idx_q  <= rd_idx_d;
            swapped_q <= swapped_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset branch.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer: table of frames with expected sorted output and
// S_SORT cycle bounds, plus hand-written reset-mid-sort and power-on checks.

module tb_sort_sequencer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    sort_sequencer #(.N(32), .DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        len;
        logic [0:7][31:0]  din;
        logic [0:7][31:0]  exp;
        logic [6:0]        bmin;
        logic [6:0]        bmax;
        logic              gaps;
        logic              bp;
        logic              ninth;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic load_frame(input vec_t v);
        for (int k = 0; k < int'(v.len); k++) begin
            if (v.gaps && k > 0) begin
                in_valid = 1'b0;
                repeat ((k % 3) + 1) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = v.din[k];
            in_last  = (k == int'(v.len) - 1);
            #1;
            chk("load_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sort_and_drain(input vec_t v);
        int n;
        int k;
        int t;
        logic stalled;
        logic [31:0] held;
        logic [3:0] pat;
        pat = 4'b1001;
        if (v.ninth) begin
            in_valid = 1'b1;
            in_data  = 32'd99;
            #1;
            chk("ninth_in_ready", {31'd0, in_ready}, 32'd0);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (n < int'(v.bmin) || n > int'(v.bmax)) begin
            errors++;
            $display("FAIL busy_cycles: got %0d, expected %0d..%0d", n, v.bmin, v.bmax);
        end
        k = 0;
        t = 0;
        stalled = 1'b0;
        held = '0;
        while (k < int'(v.len) && t < 500) begin
            out_ready = v.bp ? pat[3 - (t % 4)] : 1'b1;
            #1;
            chk("drain_out_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
            if (stalled) chk("stall_hold", out_data, held);
            if (out_ready) begin
                chk("out_data", out_data, v.exp[k]);
                chk("out_last", {31'd0, out_last}, {31'd0, (k == int'(v.len) - 1)});
                k++;
                stalled = 1'b0;
            end else begin
                held = out_data;
                stalled = 1'b1;
            end
            t++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (t >= 500) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: got %0d words, expected %0d", k, v.len);
        end
        #1;
        chk("post_drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{len: 4'd8,
                    din: {32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                          32'd0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF},
                    exp: {32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                          32'd0, 32'd2, 32'd5, 32'h7FFF_FFFF},
                    bmin: 7'd7, bmax: 7'd64, gaps: 1'b0, bp: 1'b1, ninth: 1'b0};
        vecs[1] = '{len: 4'd8,
                    din: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                    exp: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                    bmin: 7'd7, bmax: 7'd7, gaps: 1'b0, bp: 1'b0, ninth: 1'b0};
        vecs[2] = '{len: 4'd8,
                    din: {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1},
                    exp: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8},
                    bmin: 7'd7, bmax: 7'd64, gaps: 1'b0, bp: 1'b1, ninth: 1'b0};
        vecs[3] = '{len: 4'd1,
                    din: {32'd42, 224'd0},
                    exp: {32'd42, 224'd0},
                    bmin: 7'd1, bmax: 7'd1, gaps: 1'b0, bp: 1'b0, ninth: 1'b0};
        vecs[4] = '{len: 4'd2,
                    din: {32'd9, 32'hFFFF_FFF7, 192'd0},
                    exp: {32'hFFFF_FFF7, 32'd9, 192'd0},
                    bmin: 7'd1, bmax: 7'd4, gaps: 1'b0, bp: 1'b1, ninth: 1'b0};
        vecs[5] = '{len: 4'd3,
                    din: {32'd3, 32'd1, 32'd2, 160'd0},
                    exp: {32'd1, 32'd2, 32'd3, 160'd0},
                    bmin: 7'd2, bmax: 7'd9, gaps: 1'b0, bp: 1'b0, ninth: 1'b0};
        vecs[6] = '{len: 4'd8,
                    din: {32'd4, 32'd4, 32'hFFFF_FFFE, 32'd10,
                          32'd0, 32'd4, 32'hFFFF_FFFE, 32'd1},
                    exp: {32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd0, 32'd1,
                          32'd4, 32'd4, 32'd4, 32'd10},
                    bmin: 7'd7, bmax: 7'd64, gaps: 1'b1, bp: 1'b1, ninth: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            if (i == 5) continue;
            load_frame(vecs[i]);
            sort_and_drain(vecs[i]);
        end

        // Reset in the 5th S_SORT cycle of a reversed frame, then a fresh 3-word frame.
        load_frame(vecs[2]);
        #1;
        chk("midsort_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midsort_rst_busy", {31'd0, busy}, 32'd0);
        chk("midsort_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midsort_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_rst_busy", {31'd0, busy}, 32'd0);
        chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
        load_frame(vecs[5]);
        sort_and_drain(vecs[5]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
